// File: rtl/board_store.sv
// Board memory for the game core: an R x C array of piece codes updated by
// atomic commands (init, move, undo, clear-history) with a circular undo log.
module board_store #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned PIECE_W    = 4,
  parameter int unsigned HIST_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [1:0]                          cmd_op,
  input  logic [$clog2(ROWS*COLS)-1:0]        cmd_src,
  input  logic [$clog2(ROWS*COLS)-1:0]        cmd_dst,
  input  logic                                cmd_promote,
  input  logic [PIECE_W-1:0]                  cmd_piece,
  input  logic [ROWS*COLS*PIECE_W-1:0]        init_board,
  output logic [ROWS*COLS*PIECE_W-1:0]        board_flat,
  output logic [$clog2(HIST_DEPTH+1)-1:0]     hist_count,
  output logic                                done,
  output logic                                err
);

  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned HW  = $clog2(HIST_DEPTH + 1);
  localparam int unsigned PW  = $clog2(HIST_DEPTH);

  localparam logic [1:0] OP_INIT  = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_UNDO  = 2'b10;

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [AW-1:0]      src;
    logic [AW-1:0]      dst;
    logic [PIECE_W-1:0] moved;
    logic [PIECE_W-1:0] capt;
  } hist_t;

  state_t             state_q, state_d;
  logic               ready_q;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [1:0]         op_q;
  logic [AW-1:0]      src_q, dst_q;
  logic               promote_q;
  logic [PIECE_W-1:0] piece_q;

  logic [PIECE_W-1:0] sq_q [N];
  logic [PIECE_W-1:0] sq_d [N];

  hist_t              hist_q [HIST_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, prev_c;
  logic [HW-1:0]      cnt_q, cnt_d;
  logic               hist_we_c;
  hist_t              hist_wdata_c, top_c;

  logic               accept_c;
  logic               move_bad_c;

  assign accept_c   = cmd_valid && ready_q;
  assign prev_c     = (wr_q == '0) ? PW'(HIST_DEPTH - 1) : wr_q - PW'(1);
  assign top_c      = hist_q[prev_c];
  // Range checks are done one bit wider so N == 2**AW does not wrap to 0
  assign move_bad_c = ({1'b0, src_q} >= AW1'(N)) || ({1'b0, dst_q} >= AW1'(N)) ||
                      (src_q == dst_q);

  // Next-state, board update and history bookkeeping
  always_comb begin
    state_d      = state_q;
    sq_d         = sq_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    hist_we_c    = 1'b0;
    hist_wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (accept_c) state_d = EXEC;
      end
      EXEC: begin
        state_d = IDLE;
        case (op_q)
          OP_INIT: begin
            for (int unsigned i = 0; i < N; i++) begin
              sq_d[i] = init_board[i*PIECE_W +: PIECE_W];
            end
            wr_d   = '0;
            cnt_d  = '0;
            done_d = 1'b1;
          end
          OP_MOVE: begin
            if (move_bad_c || (sq_q[src_q] == '0)) begin
              err_d = 1'b1;
            end else begin
              hist_we_c          = 1'b1;
              hist_wdata_c.src   = src_q;
              hist_wdata_c.dst   = dst_q;
              hist_wdata_c.moved = sq_q[src_q];
              hist_wdata_c.capt  = sq_q[dst_q];
              sq_d[dst_q]        = promote_q ? piece_q : sq_q[src_q];
              sq_d[src_q]        = '0;
              wr_d               = (wr_q == PW'(HIST_DEPTH - 1)) ? '0 : wr_q + PW'(1);
              if (cnt_q != HW'(HIST_DEPTH)) cnt_d = cnt_q + HW'(1);
              done_d             = 1'b1;
            end
          end
          OP_UNDO: begin
            if (cnt_q == '0) begin
              err_d = 1'b1;
            end else begin
              sq_d[top_c.src] = top_c.moved;
              sq_d[top_c.dst] = top_c.capt;
              wr_d            = prev_c;
              cnt_d           = cnt_q - HW'(1);
              done_d          = 1'b1;
            end
          end
          default: begin
            wr_d   = '0;
            cnt_d  = '0;
            done_d = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command capture on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_INIT;
      src_q     <= '0;
      dst_q     <= '0;
      promote_q <= 1'b0;
      piece_q   <= '0;
    end else if (accept_c) begin
      op_q      <= cmd_op;
      src_q     <= cmd_src;
      dst_q     <= cmd_dst;
      promote_q <= cmd_promote;
      piece_q   <= cmd_piece;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) sq_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) sq_q[i] <= sq_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else if (hist_we_c) begin
      hist_q[wr_q] <= hist_wdata_c;
    end
  end

  always_comb begin
    board_flat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      board_flat[i*PIECE_W +: PIECE_W] = sq_q[i];
    end
  end

  assign cmd_ready  = ready_q;
  assign hist_count = cnt_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/board_store.md
# board_store

Parametrised board memory for the game core. It holds an R×C array of piece codes and exposes the whole array flattened for the display and logic units. Changes are applied as atomic commands (init, move, undo, clear-history) through a valid/ready handshake, and every move is recorded in a circular undo history. It replaces the bare register array and per-square write port of the previous top level.

## Interface
- ROWS, default 8: board rows.
- COLS, default 8: board columns.
- PIECE_W, default 4: bits per square. Code 0 means empty; the MSB is the colour.
- HIST_DEPTH, default 16: number of undo entries, ≥2.
- Derived: N=ROWS*COLS; AW=$clog2(N); HW=$clog2(HIST_DEPTH+1).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle; accepts a command.
- cmd_op  in  2  00 INIT, 01 MOVE, 10 UNDO, 11 CLEAR_HIST.
- cmd_src  in  AW  MOVE source square, index row*COLS+col.
- cmd_dst  in  AW  MOVE destination square.
- cmd_promote  in  1  MOVE writes cmd_piece to dst instead of the moved piece.
- cmd_piece  in  PIECE_W  promotion piece code.
- init_board  in  N*PIECE_W  position loaded by INIT. Square i is at bits [i*PIECE_W +: PIECE_W].
- board_flat  out  N*PIECE_W  registered board contents, same packing as init_board.
- hist_count  out  HW  valid undo entries, 0..HIST_DEPTH.
- done  out  1  one-cycle pulse: command completed successfully.
- err  out  1  one-cycle pulse: command rejected, no state change.

## Operation
- FSM has two states, IDLE and EXEC. cmd_ready=1 only in IDLE.
- An accept edge occurs when cmd_valid&&cmd_ready. On that edge the block registers op, src, dst, promote and piece, and moves to EXEC. init_board is sampled on the EXEC edge, so it must be held stable until done.
- On the EXEC edge the block applies the command, pulses done or err, and returns to IDLE.
- INIT: board <= init_board. History is cleared and hist_count <= 0. The command always completes with done.
- MOVE: err if src≥N, dst≥N, src==dst, or board[src]==0. Otherwise:
  - board[dst] <= promote ? cmd_piece : board[src].
  - board[src] <= 0.
  - Push {src, dst, board[src], board[dst]} to history.
- History is circular. When full, a push overwrites the oldest entry and hist_count stays at HIST_DEPTH.
- UNDO: err if hist_count==0. Otherwise pop the newest entry and apply:
  - board[src] <= moved piece. This restores the pre-promotion piece.
  - board[dst] <= captured piece, which may be 0.
  - hist_count decrements.
- CLEAR_HIST: hist_count <= 0 and the board is unchanged. Always completes with done.
- Rejected commands leave the board, history pointers and hist_count unchanged.
- Reset values:
  - Every board square is 0, so board_flat=0.
  - hist_count=0 and the write pointer is 0.
  - State is IDLE, so cmd_ready=1.
  - done=0 and err=0.
- Reset asserted mid-EXEC aborts the command with no partial write and no done/err pulse.

## Timing
- Latency: accept edge E0, apply edge E1. After E1, board_flat, hist_count, done and err reflect the result, and cmd_ready is 1 again.
- Throughput: one command per 2 cycles. cmd_valid held high across E1 is accepted at E2.
- done and err are mutually exclusive and each lasts exactly one cycle.
- cmd_* inputs are ignored while cmd_ready=0.
- History storage is registers, with no read latency. The pointer arithmetic is modulo HIST_DEPTH, so HIST_DEPTH need not be a power of two.

## Test plan
- Reset, then INIT with the standard chess layout (rank 0 white codes 0xC,0xA,0xB,0xD,0xE,0xB,0xA,0xC; rank 1 white pawns 0x9; black ranks 6/7 same piece codes with MSB 0) -> done 2 edges after accept, board_flat==init_board, hist_count=0.
- MOVE src=12 to dst=28 -> sq28=0x9, sq12=0, hist_count=1. Then UNDO -> sq12=0x9, sq28=0, hist_count=0.
- Capture: place 0x1 at sq21, MOVE 12->21 with promote=1, piece=0xD -> sq21=0xD. UNDO -> sq12=0x9, sq21=0x1.
- Errors: MOVE from an empty square, MOVE with src==dst, UNDO at hist_count=0, MOVE with src=N when N<2^AW -> each gives err, no done, and board_flat and hist_count unchanged.
- HIST_DEPTH=4: run 6 legal moves -> hist_count=4. Then 4 UNDOs restore the position after move 2, and a 5th UNDO gives err.
- Assert rst_n low one cycle after a MOVE accept -> board_flat=0, hist_count=0, cmd_ready=1, no done pulse. Also check back-to-back commands with cmd_valid held high are accepted every 2 cycles.
